// File: rtl/graphics_processor_pkg.sv
// Shared opcodes, state encodings and burst geometry for the command-list processor.
package graphics_processor_pkg;

    localparam int BURST_WORDS = 8;

    localparam logic [7:0] OP_STOP = 8'h00;
    localparam logic [7:0] OP_FILL = 8'h01;
    localparam logic [7:0] OP_LINE = 8'h02;

    typedef enum logic [2:0] {
        GP_IDLE,
        GP_FETCH,
        GP_DECODE,
        GP_FILL,
        GP_LINE_P0,
        GP_LINE_P1,
        GP_LINE_EMIT
    } gp_state_t;

    typedef enum logic [1:0] {
        FB_IDLE,
        FB_REQ,
        FB_RD0,
        FB_RD1
    } fb_state_t;

    // States that read the buffered word at ptr[4:2] and therefore need a valid block.
    function automatic logic reads_word(gp_state_t s);
        return (s == GP_DECODE) || (s == GP_LINE_P0) || (s == GP_LINE_P1);
    endfunction

endpackage

// File: rtl/gp_fetch_buffer.sv
// Issues one 32-byte DDR read per start pulse and captures the two returned beats
// into an 8-word buffer that the decoder reads by word index.
module gp_fetch_buffer
    import graphics_processor_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [25:0]  blk_addr,
    input  logic         af_full,
    input  logic         rdf_valid,
    input  logic [127:0] rdf_dout,
    input  logic [2:0]   rd_idx,
    output logic         af_wr_en,
    output logic [30:0]  af_addr_din,
    output logic         rdf_rd_en,
    output logic         done,
    output logic [31:0]  rd_word
);

    fb_state_t   state;
    logic [31:0] words [BURST_WORDS];

    assign af_wr_en  = (state == FB_REQ) && !af_full;
    assign rdf_rd_en = ((state == FB_RD0) || (state == FB_RD1)) && rdf_valid;
    assign rd_word   = words[rd_idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= FB_IDLE;
            af_addr_din <= '0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                FB_IDLE: begin
                    if (start) begin
                        af_addr_din <= {blk_addr, 5'b0};
                        state       <= FB_REQ;
                    end
                end
                FB_REQ: begin
                    if (!af_full) state <= FB_RD0;
                end
                FB_RD0: begin
                    if (rdf_valid) state <= FB_RD1;
                end
                FB_RD1: begin
                    if (rdf_valid) begin
                        state <= FB_IDLE;
                        done  <= 1'b1;
                    end
                end
                default: state <= FB_IDLE;
            endcase
        end
    end

    // Beat 0 lands in words 0-3, beat 1 in words 4-7; most-significant word first.
    always_ff @(posedge clk) begin
        if (rdf_rd_en) begin
            for (int i = 0; i < 4; i++) begin
                words[{state == FB_RD1, 2'(i)}] <= rdf_dout[127 - 32*i -: 32];
            end
        end
    end

endmodule

// File: rtl/graphics_processor.sv
// Command-list processor: fetches command words from DDR, decodes them and
// dispatches FILL requests to the frame filler and LINE requests to the line engine.
module graphics_processor
    import graphics_processor_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         rdf_valid,
    input  logic         af_full,
    input  logic [127:0] rdf_dout,
    output logic         rdf_rd_en,
    output logic         af_wr_en,
    output logic [30:0]  af_addr_din,
    input  logic         LE_ready,
    output logic [31:0]  LE_color,
    output logic [9:0]   LE_point,
    output logic         LE_color_valid,
    output logic         LE_x0_valid,
    output logic         LE_y0_valid,
    output logic         LE_x1_valid,
    output logic         LE_y1_valid,
    output logic         LE_trigger,
    output logic [31:0]  LE_frame,
    input  logic         FF_ready,
    output logic         FF_valid,
    output logic [23:0]  FF_color,
    output logic [31:0]  FF_frame,
    input  logic [31:0]  GP_CODE,
    input  logic [31:0]  GP_FRAME,
    input  logic         GP_valid
);

    gp_state_t   state;
    gp_state_t   ret_state;
    logic [31:0] ptr;
    logic [31:0] frame;
    logic        need_fetch;
    logic        fetch_start;
    logic        fb_done;
    logic [31:0] word;
    logic [7:0]  opcode;
    logic        word_last;
    logic [23:0] color;
    logic [9:0]  x0, y0, x1, y1;
    logic [2:0]  emit_step;

    logic        leave;
    logic        consume;
    logic        wrap_next;
    gp_state_t   leave_to;

    assign LE_frame  = frame;
    assign FF_frame  = frame;
    assign opcode    = word[31:24];
    assign word_last = &ptr[4:2];

    gp_fetch_buffer u_fetch (
        .clk         (clk),
        .rst         (rst),
        .start       (fetch_start),
        .blk_addr    (ptr[30:5]),
        .af_full     (af_full),
        .rdf_valid   (rdf_valid),
        .rdf_dout    (rdf_dout),
        .rd_idx      (ptr[4:2]),
        .af_wr_en    (af_wr_en),
        .af_addr_din (af_addr_din),
        .rdf_rd_en   (rdf_rd_en),
        .done        (fb_done),
        .rd_word     (word)
    );

    // Where the FSM goes when the current step completes, and whether it used up the last buffered word.
    always_comb begin
        leave     = 1'b0;
        consume   = 1'b0;
        leave_to  = GP_DECODE;
        wrap_next = need_fetch;
        case (state)
            GP_DECODE: begin
                if (opcode == OP_FILL || opcode == OP_LINE) begin
                    leave     = 1'b1;
                    consume   = 1'b1;
                    leave_to  = (opcode == OP_FILL) ? GP_FILL : GP_LINE_P0;
                    wrap_next = word_last;
                end
            end
            GP_FILL:      leave = FF_ready;
            GP_LINE_P0: begin
                leave     = 1'b1;
                consume   = 1'b1;
                leave_to  = GP_LINE_P1;
                wrap_next = word_last;
            end
            GP_LINE_P1: begin
                leave     = 1'b1;
                consume   = 1'b1;
                leave_to  = GP_LINE_EMIT;
                wrap_next = word_last;
            end
            GP_LINE_EMIT: leave = (emit_step == 3'd5);
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= GP_IDLE;
            ret_state      <= GP_DECODE;
            need_fetch     <= 1'b0;
            fetch_start    <= 1'b0;
            ptr            <= '0;
            frame          <= '0;
            emit_step      <= '0;
            FF_valid       <= 1'b0;
            FF_color       <= '0;
            LE_color       <= '0;
            LE_point       <= '0;
            LE_color_valid <= 1'b0;
            LE_x0_valid    <= 1'b0;
            LE_y0_valid    <= 1'b0;
            LE_x1_valid    <= 1'b0;
            LE_y1_valid    <= 1'b0;
            LE_trigger     <= 1'b0;
        end else begin
            fetch_start    <= 1'b0;
            FF_valid       <= 1'b0;
            LE_color_valid <= 1'b0;
            LE_x0_valid    <= 1'b0;
            LE_y0_valid    <= 1'b0;
            LE_x1_valid    <= 1'b0;
            LE_y1_valid    <= 1'b0;
            LE_trigger     <= 1'b0;

            case (state)
                GP_IDLE: begin
                    if (GP_valid) begin
                        ptr         <= GP_CODE;
                        frame       <= GP_FRAME;
                        need_fetch  <= 1'b0;
                        ret_state   <= GP_DECODE;
                        fetch_start <= 1'b1;
                        state       <= GP_FETCH;
                    end
                end
                GP_FETCH: begin
                    if (fb_done) state <= ret_state;
                end
                GP_DECODE: begin
                    color <= word[23:0];
                    if (opcode == OP_STOP || !leave) state <= GP_IDLE;
                end
                GP_FILL: begin
                    if (FF_ready) begin
                        FF_valid <= 1'b1;
                        FF_color <= color;
                    end
                end
                GP_LINE_P0: begin
                    x0 <= word[25:16];
                    y0 <= word[9:0];
                end
                GP_LINE_P1: begin
                    x1        <= word[25:16];
                    y1        <= word[9:0];
                    emit_step <= 3'd0;
                end
                GP_LINE_EMIT: begin
                    case (emit_step)
                        3'd0: if (LE_ready) begin
                            LE_color_valid <= 1'b1;
                            LE_color       <= {8'h00, color};
                            emit_step      <= 3'd1;
                        end
                        3'd1: begin LE_x0_valid <= 1'b1; LE_point <= x0; emit_step <= 3'd2; end
                        3'd2: begin LE_y0_valid <= 1'b1; LE_point <= y0; emit_step <= 3'd3; end
                        3'd3: begin LE_x1_valid <= 1'b1; LE_point <= x1; emit_step <= 3'd4; end
                        3'd4: begin LE_y1_valid <= 1'b1; LE_point <= y1; emit_step <= 3'd5; end
                        default: begin LE_trigger <= 1'b1; emit_step <= 3'd0; end
                    endcase
                end
                default: state <= GP_IDLE;
            endcase

            // Crossing past word 7 refetches the next block before any state that reads a word.
            if (leave) begin
                if (consume) ptr <= ptr + 32'd4;
                if (wrap_next && reads_word(leave_to)) begin
                    state       <= GP_FETCH;
                    ret_state   <= leave_to;
                    fetch_start <= 1'b1;
                    need_fetch  <= 1'b0;
                end else begin
                    state      <= leave_to;
                    need_fetch <= wrap_next;
                end
            end
        end
    end

endmodule

// File: tb/tb_graphics_processor.sv
// Scoreboard bench: a DDR model serves bursts from a word memory and every DUT output event is matched against a queue.
module tb_graphics_processor;

    logic         clk = 1'b0;
    logic         rst;
    logic         rdf_valid;
    logic         af_full;
    logic [127:0] rdf_dout;
    logic         rdf_rd_en;
    logic         af_wr_en;
    logic [30:0]  af_addr_din;
    logic         LE_ready;
    logic [31:0]  LE_color;
    logic [9:0]   LE_point;
    logic         LE_color_valid, LE_x0_valid, LE_y0_valid, LE_x1_valid, LE_y1_valid;
    logic         LE_trigger;
    logic [31:0]  LE_frame;
    logic         FF_ready;
    logic         FF_valid;
    logic [23:0]  FF_color;
    logic [31:0]  FF_frame;
    logic [31:0]  GP_CODE;
    logic [31:0]  GP_FRAME;
    logic         GP_valid;

    always #5 clk = ~clk;

    graphics_processor dut (
        .clk(clk), .rst(rst),
        .rdf_valid(rdf_valid), .af_full(af_full), .rdf_dout(rdf_dout),
        .rdf_rd_en(rdf_rd_en), .af_wr_en(af_wr_en), .af_addr_din(af_addr_din),
        .LE_ready(LE_ready), .LE_color(LE_color), .LE_point(LE_point),
        .LE_color_valid(LE_color_valid), .LE_x0_valid(LE_x0_valid), .LE_y0_valid(LE_y0_valid),
        .LE_x1_valid(LE_x1_valid), .LE_y1_valid(LE_y1_valid), .LE_trigger(LE_trigger),
        .LE_frame(LE_frame), .FF_ready(FF_ready), .FF_valid(FF_valid), .FF_color(FF_color),
        .FF_frame(FF_frame), .GP_CODE(GP_CODE), .GP_FRAME(GP_FRAME), .GP_valid(GP_valid)
    );

    localparam logic [3:0] K_REQ = 4'd1, K_FILL = 4'd2, K_LCOL = 4'd3, K_X0 = 4'd4,
                           K_Y0 = 4'd5, K_X1 = 4'd6, K_Y1 = 4'd7, K_TRIG = 4'd8;

    typedef logic [35:0] evt_t;
    evt_t        exp_q[$];
    int          n_vec = 0;
    int          n_err = 0;
    longint      cyc = 0;
    longint      t_col = 0;
    int          ff_pulses = 0;
    logic [31:0] mem [logic [31:0]];
    logic [30:0] req_q[$];
    logic        beat = 1'b0;

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] expv);
        n_vec++;
        if (got !== expv) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, expv);
        end
    endtask

    task automatic on_evt(input logic [3:0] k, input logic [31:0] v);
        evt_t e;
        evt_t x;
        e = {k, v};
        if (exp_q.size() == 0) begin
            chk_eq("unexpected_evt", 64'(e), 64'h0);
        end else begin
            x = exp_q.pop_front();
            chk_eq("evt", 64'(e), 64'(x));
        end
    endtask

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        logic [31:0] key;
        key = a >> 2;
        return mem.exists(key) ? mem[key] : 32'h0;
    endfunction

    function automatic logic [127:0] beat_data(input logic [30:0] a, input logic b);
        logic [127:0] d;
        for (int j = 0; j < 4; j++) begin
            d[127 - 32*j -: 32] = mem_rd(32'(a) + (b ? 32'd16 : 32'd0) + 32'(4*j));
        end
        return d;
    endfunction

    function automatic logic [31:0] lw(input logic [9:0] x, input logic [9:0] y);
        return {6'b0, x, 6'b0, y};
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // DDR model: accepts a request, then returns two beats from mem.
    always @(posedge clk) begin
        if (rst) begin
            req_q.delete();
            beat      <= 1'b0;
            rdf_valid <= 1'b0;
            rdf_dout  <= '0;
        end else begin
            if (rdf_rd_en && beat) req_q.delete(0);
            if (af_wr_en && !af_full) req_q.push_back(af_addr_din);
            if (rdf_rd_en) beat <= ~beat;
            rdf_valid <= (req_q.size() != 0);
            rdf_dout  <= (req_q.size() != 0) ? beat_data(req_q[0], rdf_rd_en ? ~beat : beat) : '0;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (af_wr_en) begin
                if (af_full) chk_eq("af_wr_while_full", 64'd1, 64'd0);
                else on_evt(K_REQ, {1'b0, af_addr_din});
            end
            if (FF_valid) begin
                on_evt(K_FILL, {8'h0, FF_color});
                ff_pulses <= ff_pulses + 1;
            end
            if ($countones({LE_color_valid, LE_x0_valid, LE_y0_valid, LE_x1_valid, LE_y1_valid, LE_trigger}) > 1)
                chk_eq("le_onehot", 64'd0, 64'd1);
            if (LE_color_valid) begin
                on_evt(K_LCOL, LE_color);
                t_col <= cyc;
            end
            if (LE_x0_valid) on_evt(K_X0, {22'h0, LE_point});
            if (LE_y0_valid) on_evt(K_Y0, {22'h0, LE_point});
            if (LE_x1_valid) on_evt(K_X1, {22'h0, LE_point});
            if (LE_y1_valid) on_evt(K_Y1, {22'h0, LE_point});
            if (LE_trigger) begin
                on_evt(K_TRIG, 32'h0);
                chk_eq("line_span", 64'(cyc - t_col), 64'd5);
            end
        end
    end

    task automatic start(input logic [31:0] code, input logic [31:0] frm);
        @(posedge clk); #1;
        GP_CODE  = code;
        GP_FRAME = frm;
        GP_valid = 1'b1;
        @(posedge clk); #1;
        GP_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 2000 && exp_q.size() != 0; i++) @(negedge clk);
        chk_eq("drain", 64'(exp_q.size()), 64'd0);
        repeat (20) @(negedge clk);
    endtask

    task automatic check_quiet(input string tag);
        chk_eq(tag, 64'({rdf_rd_en, af_wr_en, FF_valid, LE_color_valid, LE_x0_valid,
                          LE_y0_valid, LE_x1_valid, LE_y1_valid, LE_trigger}), 64'd0);
    endtask

    initial begin
        int snap;
        rst = 1'b1; GP_valid = 1'b0; GP_CODE = '0; GP_FRAME = '0;
        af_full = 1'b0; FF_ready = 1'b1; LE_ready = 1'b1;

        repeat (10) @(posedge clk);
        @(negedge clk);
        check_quiet("rst_strobes");
        chk_eq("rst_af_addr", 64'(af_addr_din), 64'd0);
        chk_eq("rst_le_point", 64'(LE_point), 64'd0);
        chk_eq("rst_le_color", 64'(LE_color), 64'd0);
        chk_eq("rst_ff_color", 64'(FF_color), 64'd0);
        chk_eq("rst_le_frame", 64'(LE_frame), 64'd0);
        chk_eq("rst_ff_frame", 64'(FF_frame), 64'd0);
        @(posedge clk); #1 rst = 1'b0;

        // Unaligned pointer (word 3) with the address FIFO full at first.
        mem[32'h1000abcc >> 2] = 32'h01123456;
        mem[32'h1000abd0 >> 2] = 32'h00000000;
        af_full = 1'b1;
        exp_q.push_back({K_REQ, 32'h1000abc0});
        exp_q.push_back({K_FILL, 32'h00123456});
        start(32'h1000abcd, 32'h10400000);
        repeat (6) @(posedge clk);
        @(negedge clk);
        chk_eq("le_frame", 64'(LE_frame), 64'h10400000);
        chk_eq("ff_frame", 64'(FF_frame), 64'h10400000);
        chk_eq("af_hold", 64'(af_wr_en), 64'd0);
        @(posedge clk); #1 af_full = 1'b0;
        drain();

        // Fill then STOP from word 0.
        mem[32'h2000 >> 2] = 32'h01deadbe; mem[32'h2004 >> 2] = 32'h00000000;
        mem[32'h2008 >> 2] = 32'h01ffffff; mem[32'h200c >> 2] = 32'h01aedefe;
        mem[32'h2010 >> 2] = 32'h01222222; mem[32'h2014 >> 2] = 32'h01333333;
        mem[32'h2018 >> 2] = 32'h01444444; mem[32'h201c >> 2] = 32'h01aaaaaa;
        snap = ff_pulses;
        exp_q.push_back({K_REQ, 32'h00002000});
        exp_q.push_back({K_FILL, 32'h00deadbe});
        start(32'h2000, 32'h20000000);
        drain();
        chk_eq("fill_once", 64'(ff_pulses - snap), 64'd1);

        // Same list while the filler is busy.
        FF_ready = 1'b0;
        snap = ff_pulses;
        exp_q.push_back({K_REQ, 32'h00002000});
        exp_q.push_back({K_FILL, 32'h00deadbe});
        start(32'h2000, 32'h20000000);
        repeat (30) @(negedge clk);
        chk_eq("ff_held", 64'(ff_pulses - snap), 64'd0);
        @(posedge clk); #1 FF_ready = 1'b1;
        drain();
        chk_eq("fill_once_late", 64'(ff_pulses - snap), 64'd1);

        // Line from word 0; a second start while busy must be ignored.
        mem[32'h3000 >> 2] = 32'h02ff0000;
        mem[32'h3004 >> 2] = lw(10'd10, 10'd20);
        mem[32'h3008 >> 2] = lw(10'd300, 10'd400);
        mem[32'h300c >> 2] = 32'h00000000;
        mem[32'h5000 >> 2] = 32'h01777777;
        exp_q.push_back({K_REQ, 32'h00003000});
        exp_q.push_back({K_LCOL, 32'h00ff0000});
        exp_q.push_back({K_X0, 32'd10});
        exp_q.push_back({K_Y0, 32'd20});
        exp_q.push_back({K_X1, 32'd300});
        exp_q.push_back({K_Y1, 32'd400});
        exp_q.push_back({K_TRIG, 32'd0});
        start(32'h3000, 32'h30000000);
        start(32'h5000, 32'h50000000);
        @(negedge clk);
        chk_eq("frame_kept", 64'(LE_frame), 64'h30000000);
        drain();

        // Line at word 6: operand word 2 lives in the next block.
        mem[32'h4018 >> 2] = 32'h02123456;
        mem[32'h401c >> 2] = lw(10'd1, 10'd2);
        mem[32'h4020 >> 2] = lw(10'd1023, 10'd0);
        mem[32'h4024 >> 2] = 32'h01abcdef;
        mem[32'h4028 >> 2] = 32'h00000000;
        exp_q.push_back({K_REQ, 32'h00004000});
        exp_q.push_back({K_REQ, 32'h00004020});
        exp_q.push_back({K_LCOL, 32'h00123456});
        exp_q.push_back({K_X0, 32'd1});
        exp_q.push_back({K_Y0, 32'd2});
        exp_q.push_back({K_X1, 32'd1023});
        exp_q.push_back({K_Y1, 32'd0});
        exp_q.push_back({K_TRIG, 32'd0});
        exp_q.push_back({K_FILL, 32'h00abcdef});
        start(32'h4018, 32'h40000000);
        drain();

        // Reset in the middle of a line dispatch.
        exp_q.push_back({K_REQ, 32'h00003000});
        exp_q.push_back({K_LCOL, 32'h00ff0000});
        exp_q.push_back({K_X0, 32'd10});
        start(32'h3000, 32'h30000000);
        for (int i = 0; i < 300 && !LE_x0_valid; i++) @(negedge clk);
        chk_eq("x0_seen", 64'(LE_x0_valid), 64'd1);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 exp_q.delete();
        @(negedge clk);
        check_quiet("midrst_strobes");
        chk_eq("midrst_af_addr", 64'(af_addr_din), 64'd0);
        chk_eq("midrst_le_point", 64'(LE_point), 64'd0);
        chk_eq("midrst_frame", 64'(LE_frame), 64'd0);
        @(posedge clk); #1 rst = 1'b0;
        repeat (20) @(negedge clk);
        check_quiet("post_rst_idle");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
